// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter; queues scan codes and sends 11-bit frames.
// Optional host clock-inhibit input is enabled by defining PS2_TX_INHIBIT_EN.
module ps2_kbd_tx #(
    parameter int PS2DIV     = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
`ifdef PS2_TX_INHIBIT_EN
    input  logic       ps2_inhibit,
`endif
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_kbd_clk,
    output logic       ps2_kbd_data
);

    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = AW + 1;
    localparam int GAP_LEN = (GAP_HALVES > 0) ? GAP_HALVES * PS2DIV : 1;
    localparam int DIV_MAX = (GAP_LEN > PS2DIV) ? GAP_LEN : PS2DIV;
    localparam int DW      = $clog2(DIV_MAX);
    localparam logic [DW-1:0] HALF_LAST = DW'(PS2DIV - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, overflow_reg;

    state_t        state_reg;
    logic [DW-1:0] div_reg;
    logic [3:0]    bit_reg;
    logic [10:0]   sr_reg;
    logic          clk_reg;

    logic          push, pop, start, abort;
    logic [7:0]    head;

`ifdef PS2_TX_INHIBIT_EN
    // An aborted byte is kept in byte_reg and takes priority over the FIFO head,
    // so it cannot be lost even if the FIFO filled up meanwhile.
    logic          pend_reg;
    logic [7:0]    byte_reg;

    always_comb begin
        head  = pend_reg ? byte_reg : mem[rd_ptr_reg];
        start = (state_reg == IDLE) && !ps2_inhibit && (pend_reg || !empty_reg);
        pop   = start && !pend_reg;
        abort = ps2_inhibit && ((state_reg == HIGH) || (state_reg == LOW)) && (bit_reg != 4'd10);
    end
`else
    always_comb begin
        head  = mem[rd_ptr_reg];
        start = (state_reg == IDLE) && !empty_reg;
        pop   = start;
        abort = 1'b0;
    end
`endif

    assign push = wr_en && !full_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (!push && pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg    <= count_next;
            full_reg     <= (count_next == CW'(FIFO_DEPTH));
            empty_reg    <= (count_next == '0);
            overflow_reg <= wr_en && full_reg;
        end
    end

    // Data line is sr_reg[0] directly; sr_reg is all ones whenever no frame is on the wire.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            sr_reg    <= '1;
            clk_reg   <= 1'b1;
`ifdef PS2_TX_INHIBIT_EN
            pend_reg  <= 1'b0;
            byte_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    div_reg <= '0;
                    if (start) begin
                        sr_reg    <= {1'b1, ~^head, head, 1'b0};
                        bit_reg   <= '0;
                        state_reg <= HIGH;
`ifdef PS2_TX_INHIBIT_EN
                        byte_reg  <= head;
                        pend_reg  <= 1'b0;
`endif
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state_reg <= GAP;
                        div_reg   <= '0;
                        clk_reg   <= 1'b1;
                        sr_reg    <= '1;
`ifdef PS2_TX_INHIBIT_EN
                        pend_reg  <= 1'b1;
`endif
                    end else if (div_reg == HALF_LAST) begin
                        div_reg   <= '0;
                        clk_reg   <= 1'b0;
                        state_reg <= LOW;
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end
                LOW: begin
                    if (abort) begin
                        state_reg <= GAP;
                        div_reg   <= '0;
                        clk_reg   <= 1'b1;
                        sr_reg    <= '1;
`ifdef PS2_TX_INHIBIT_EN
                        pend_reg  <= 1'b1;
`endif
                    end else if (div_reg == HALF_LAST) begin
                        div_reg <= '0;
                        clk_reg <= 1'b1;
                        if (bit_reg == 4'd10) begin
                            state_reg <= GAP;
                            sr_reg    <= '1;
                        end else begin
                            sr_reg    <= {1'b1, sr_reg[10:1]};
                            bit_reg   <= bit_reg + 4'd1;
                            state_reg <= HIGH;
                        end
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end
                GAP: begin
                    if (div_reg == GAP_LAST) begin
                        div_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign full         = full_reg;
    assign empty        = empty_reg;
    assign overflow     = overflow_reg;
    assign busy         = (state_reg != IDLE);
    assign ps2_kbd_clk  = clk_reg;
    assign ps2_kbd_data = sr_reg[0];

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: stimulus queues hand-computed frames, a monitor decodes the PS/2 lines.
// Inhibit scenario is compiled only when PS2_TX_INHIBIT_EN is defined.
module tb_ps2_kbd_tx;
    localparam int PS2DIV     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_HALVES = 4;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, overflow, ps2_kbd_clk, ps2_kbd_data;
`ifdef PS2_TX_INHIBIT_EN
    logic       ps2_inhibit = 1'b0;
`endif

    ps2_kbd_tx #(.PS2DIV(PS2DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_HALVES(GAP_HALVES)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
`ifdef PS2_TX_INHIBIT_EN
        .ps2_inhibit  (ps2_inhibit),
`endif
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .overflow     (overflow),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Expected frames, bit 0 = start bit; parity is supplied by hand per byte.
    logic [10:0] exp_q[$];
    int          starts[$];
    int          fall_cnt = 0;

    task automatic push_exp(input logic [7:0] b, input logic p);
        exp_q.push_back({1'b1, p, b, 1'b0});
    endtask

    function automatic int start_at(input int i);
        if (i < starts.size())
            return starts[i];
        return -1000000;
    endfunction

    // Monitor: samples data on each falling PS/2 clock; a long high run discards a partial frame.
    int          idx = 0;
    int          high_run = 0;
    logic        prev_clk = 1'b1;
    logic [10:0] rx = '0;
    always @(negedge clk_sys) begin
        if (reset) begin
            idx      = 0;
            high_run = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_kbd_clk) begin
                fall_cnt++;
                if (idx == 0)
                    starts.push_back(cyc);
                rx[idx] = ps2_kbd_data;
                idx++;
                if (idx == 11) begin
                    idx = 0;
                    $display("rx frame=%03h data=%02h parity=%0b", rx, rx[8:1], rx[9]);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%03h required=none", rx);
                    end else begin
                        check("frame", 32'(rx), 32'(exp_q.pop_front()));
                    end
                end
            end
            if (ps2_kbd_clk) high_run++;
            else high_run = 0;
            if (high_run > PS2DIV + 2)
                idx = 0;
            prev_clk = ps2_kbd_clk;
        end
    end

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && empty && !busy) && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, 32'(exp_q.size() == 0 && empty && !busy), 32'd1);
    endtask

    task automatic wait_falls(input int target, input int budget, input string name);
        int n = 0;
        while (fall_cnt < target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, 32'(fall_cnt >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, s0, f0, n;
        logic        saw_low;
        logic [7:0]  burst [6];
        logic        burst_p [5];
        burst   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
        burst_p = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // 1: reset and idle
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check("reset_clk", 32'(ps2_kbd_clk), 32'd1);
        check("reset_data", 32'(ps2_kbd_data), 32'd1);
        saw_low = 1'b0;
        repeat (50) begin
            @(negedge clk_sys);
            if (!ps2_kbd_clk || !ps2_kbd_data) saw_low = 1'b1;
        end
        check("idle_lines_low", 32'(saw_low), 32'd0);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_full", 32'(full), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_overflow", 32'(overflow), 32'd0);
        check("idle_falls", 32'(fall_cnt), 32'd0);

        // 2: single byte latency and frame content
        s0 = starts.size();
        @(negedge clk_sys);
        wr_en = 1'b1; wr_data = 8'h1C; t = cyc;
        push_exp(8'h1C, 1'b0);
        $display("wr data=1c");
        @(negedge clk_sys);
        wr_en = 1'b0;
        check("empty_after_wr", 32'(empty), 32'd0);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk_sys); n++; end
        while (busy && n < 300) begin @(negedge clk_sys); n++; end
        check("busy_fall_delay", 32'(cyc - t), 32'd106);
        check("first_fall_delay", 32'(start_at(s0) - t), 32'd6);
        wait_quiet(200, "single_done");

        // 3: back-to-back bytes
        s0 = starts.size();
        @(negedge clk_sys);
        wr_en = 1'b1; wr_data = 8'hF0;
        push_exp(8'hF0, 1'b1);
        $display("wr data=f0");
        @(negedge clk_sys);
        wr_data = 8'h1C;
        push_exp(8'h1C, 1'b0);
        $display("wr data=1c");
        @(negedge clk_sys);
        wr_en = 1'b0;
        wait_quiet(400, "b2b_done");
        check("b2b_period", 32'(start_at(s0 + 1) - start_at(s0)), 32'd105);

        // 4: burst of 6 into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            wr_en = 1'b1; wr_data = burst[i];
            if (i < 5) push_exp(burst[i], burst_p[i]);
            $display("wr data=%02h", burst[i]);
            if (i == 5) begin
                check("burst_full", 32'(full), 32'd1);
                check("burst_no_early_overflow", 32'(overflow), 32'd0);
            end
        end
        @(negedge clk_sys);
        wr_en = 1'b0;
        check("overflow_pulse", 32'(overflow), 32'd1);
        @(negedge clk_sys);
        check("overflow_clear", 32'(overflow), 32'd0);
        wait_quiet(900, "burst_done");

        // 5: reset during LOW of bit 4
        f0 = fall_cnt;
        @(negedge clk_sys);
        wr_en = 1'b1; wr_data = 8'hAA;
        push_exp(8'hAA, 1'b1);
        $display("wr data=aa");
        @(negedge clk_sys);
        wr_en = 1'b0;
        wait_falls(f0 + 5, 200, "reach_bit4");
        reset = 1'b1;
        @(negedge clk_sys);
        check("rst_clk", 32'(ps2_kbd_clk), 32'd1);
        check("rst_data", 32'(ps2_kbd_data), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        f0 = fall_cnt;
        repeat (100) @(negedge clk_sys);
        check("no_falls_after_reset", 32'(fall_cnt - f0), 32'd0);

`ifdef PS2_TX_INHIBIT_EN
        // 6: host inhibit during bit 3, byte resent, next byte follows
        f0 = fall_cnt;
        @(negedge clk_sys);
        wr_en = 1'b1; wr_data = 8'h55;
        push_exp(8'h55, 1'b1);
        $display("wr data=55");
        @(negedge clk_sys);
        wr_data = 8'h12;
        push_exp(8'h12, 1'b1);
        $display("wr data=12");
        @(negedge clk_sys);
        wr_en = 1'b0;
        wait_falls(f0 + 4, 200, "reach_bit3");
        ps2_inhibit = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("inh_clk", 32'(ps2_kbd_clk), 32'd1);
        check("inh_data", 32'(ps2_kbd_data), 32'd1);
        f0 = fall_cnt;
        repeat (40) @(negedge clk_sys);
        check("inh_no_falls", 32'(fall_cnt - f0), 32'd0);
        ps2_inhibit = 1'b0;
        wait_quiet(400, "inhibit_done");
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
